// File: rtl/spi_reg_master.sv
// SPI initiator for the SID register bank: buffers {addr,data} commands in a small FIFO
// and shifts each one out as a 16-bit CPOL=0 / CPHA=0 frame, MSB first.
module spi_reg_master #(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYC    = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [2:0]                    cmd_addr,
    input  logic [7:0]                    cmd_data,
    output logic                          spi_cs_n,
    output logic                          spi_clk,
    output logic                          spi_mosi,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int LVL_W   = PTR_W + 1;
    localparam int CNT_MAX = (CLK_DIV > GAP_CYC) ? CLK_DIV : GAP_CYC;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        HIGH,
        LOW,
        HOLD,
        GAP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] div_cnt;
    logic [3:0]       bit_idx;
    logic [14:0]      tx_bits;

    logic [10:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [10:0]      head;
    logic             push;
    logic             pop;

    assign cmd_ready = (fifo_level != LVL_FULL);
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state == IDLE) && (fifo_level != '0);
    assign head      = mem[rd_ptr];
    assign busy      = (state != IDLE) || (fifo_level != '0);

    // NOTE: the storage array has no reset; the level and pointers alone define which
    // entries are valid, so flushing them is enough and the array can map to plain RAM.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr] <= {cmd_addr, cmd_data};
        end
    end

    // NOTE: every register here uses <= so all updates see the pre-edge values of
    // push/pop and the level, regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LVL_ONE;
                2'b01:   fifo_level <= fifo_level - LVL_ONE;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // The 16-bit shifter is {spi_mosi, tx_bits}: the bit on the wire is its MSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            div_cnt  <= '0;
            bit_idx  <= '0;
            tx_bits  <= '0;
            spi_cs_n <= 1'b1;
            spi_clk  <= 1'b0;
            spi_mosi <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        spi_mosi <= head[10];
                        tx_bits  <= {head[9:8], 5'b0, head[7:0]};
                        spi_cs_n <= 1'b0;
                        bit_idx  <= '0;
                        div_cnt  <= '0;
                        state    <= SETUP;
                    end
                end

                SETUP, LOW: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        spi_clk <= 1'b1;
                        state   <= HIGH;
                    end else begin
                        div_cnt <= div_cnt + CNT_ONE;
                    end
                end

                HIGH: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        spi_clk <= 1'b0;
                        if (bit_idx == 4'd15) begin
                            state <= HOLD;
                        end else begin
                            bit_idx  <= bit_idx + 4'd1;
                            spi_mosi <= tx_bits[14];
                            tx_bits  <= {tx_bits[13:0], 1'b0};
                            state    <= LOW;
                        end
                    end else begin
                        div_cnt <= div_cnt + CNT_ONE;
                    end
                end

                HOLD: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt  <= '0;
                        spi_cs_n <= 1'b1;
                        spi_mosi <= 1'b0;
                        state    <= GAP;
                    end else begin
                        div_cnt <= div_cnt + CNT_ONE;
                    end
                end

                GAP: begin
                    if (div_cnt == GAP_LAST) begin
                        div_cnt <= '0;
                        state   <= IDLE;
                    end else begin
                        div_cnt <= div_cnt + CNT_ONE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_reg_master.sv
// Directed bench for spi_reg_master: a negedge monitor decodes SPI frames and timing,
// and a linear stimulus sequence compares them against hand-computed values.
module tb_spi_reg_master;

    localparam int CLK_DIV    = 4;
    localparam int GAP_CYC    = 4;
    localparam int FIFO_DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_addr = '0;
    logic [7:0] cmd_data = '0;
    logic       spi_cs_n;
    logic       spi_clk;
    logic       spi_mosi;
    logic       busy;
    logic [2:0] fifo_level;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    spi_reg_master #(
        .CLK_DIV    (CLK_DIV),
        .GAP_CYC    (GAP_CYC),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_addr   (cmd_addr),
        .cmd_data   (cmd_data),
        .spi_cs_n   (spi_cs_n),
        .spi_clk    (spi_clk),
        .spi_mosi   (spi_mosi),
        .busy       (busy),
        .fifo_level (fifo_level)
    );

    typedef struct {
        logic [15:0] word;
        int          bits;
        int          low_len;
        int          first_rise;
    } frame_t;

    frame_t frames[$];
    int     gaps[$];

    logic        prev_cs   = 1'b1;
    logic        prev_sclk = 1'b0;
    logic        prev_mosi = 1'b0;
    logic [15:0] sh        = '0;
    int          bits_cnt  = 0;
    int          low_len   = 0;
    int          since_fall = 0;
    int          first_rise = -1;
    int          gap_len   = 0;
    bit          seen_frame = 1'b0;
    int          mosi_viol = 0;
    int          sclk_viol = 0;
    int          cs_falls  = 0;

    // Slave-side view: sample MOSI on SCLK rises, time CS low/high windows in clk cycles.
    always @(negedge clk) begin
        prev_cs   <= spi_cs_n;
        prev_sclk <= spi_clk;
        prev_mosi <= spi_mosi;
        if (prev_cs === 1'b1 && spi_cs_n === 1'b0) begin
            cs_falls <= cs_falls + 1;
            if (seen_frame && gap_len <= 64) gaps.push_back(gap_len);
            sh         <= '0;
            bits_cnt   <= 0;
            low_len    <= 1;
            since_fall <= 0;
            first_rise <= -1;
        end else if (spi_cs_n === 1'b0) begin
            low_len    <= low_len + 1;
            since_fall <= since_fall + 1;
            if (prev_sclk === 1'b0 && spi_clk === 1'b1) begin
                sh       <= {sh[14:0], spi_mosi};
                bits_cnt <= bits_cnt + 1;
                if (first_rise < 0) first_rise <= since_fall + 1;
            end
        end
        if (prev_cs === 1'b0 && spi_cs_n === 1'b1) begin
            frames.push_back('{sh, bits_cnt, low_len, first_rise});
            seen_frame <= 1'b1;
            gap_len    <= 1;
        end else if (spi_cs_n === 1'b1) begin
            gap_len <= gap_len + 1;
        end
        if (prev_sclk === 1'b1 && spi_clk === 1'b1 && spi_mosi !== prev_mosi)
            mosi_viol <= mosi_viol + 1;
        if (prev_cs === 1'b1 && spi_cs_n === 1'b1 && spi_clk !== prev_sclk)
            sclk_viol <= sclk_viol + 1;
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_frames(input string tag, input int n, input int limit);
        int guard = 0;
        while (frames.size() < n && guard < limit) begin
            tick();
            guard++;
        end
        check(tag, frames.size(), n);
    endtask

    task automatic settle();
        repeat (100) tick();
        frames.delete();
        gaps.delete();
    endtask

    logic [15:0] t2_words [5] = '{16'h0010, 16'h2011, 16'h4012, 16'h6013, 16'h8014};
    int          t2_levels[8] = '{0, 1, 1, 2, 3, 4, 4, 4};
    logic [15:0] exp_q[$];

    initial begin
        frame_t      f;
        int          accepted;
        int          sent;
        int          guard;
        int          falls_snap;
        logic [15:0] w;

        // Reset state
        tick();
        tick();
        check("rst_cs_n", spi_cs_n, 1);
        check("rst_sclk", spi_clk, 0);
        check("rst_mosi", spi_mosi, 0);
        check("rst_level", fifo_level, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        tick();
        check("rst_ready", cmd_ready, 1);
        repeat (2) tick();

        // Single frame addr=6 data=0xA5
        cmd_addr  = 3'd6;
        cmd_data  = 8'hA5;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check("t1_level_after_push", fifo_level, 1);
        check("t1_cs_not_yet", spi_cs_n, 1);
        check("t1_busy_queued", busy, 1);
        tick();
        check("t1_cs_fall", spi_cs_n, 0);
        check("t1_level_popped", fifo_level, 0);
        wait_frames("t1_frame_count", 1, 400);
        check("t1_busy_gap_start", busy, 1);
        repeat (3) tick();
        check("t1_busy_gap_end", busy, 1);
        tick();
        check("t1_busy_clear", busy, 0);
        if (frames.size() > 0) begin
            f = frames.pop_front();
            check("t1_word", f.word, 16'hC0A5);
            check("t1_rises", f.bits, 16);
            check("t1_cs_low_len", f.low_len, 33 * CLK_DIV);
            check("t1_first_rise", f.first_rise, CLK_DIV);
        end
        settle();

        // Held valid, 8 offers into depth-4 FIFO: 5 accepted, ready low from offer 5
        accepted = 0;
        for (int i = 0; i < 8; i++) begin
            cmd_addr  = 3'(i);
            cmd_data  = 8'h10 + 8'(i);
            cmd_valid = 1'b1;
            check($sformatf("t2_level_%0d", i), fifo_level, t2_levels[i]);
            check($sformatf("t2_ready_%0d", i), cmd_ready, (i < 5) ? 1 : 0);
            if (cmd_ready) accepted++;
            tick();
        end
        cmd_valid = 1'b0;
        check("t2_accepted", accepted, 5);
        wait_frames("t2_frame_count", 5, 1200);
        for (int i = 0; i < 5; i++) begin
            if (frames.size() > 0) begin
                f = frames.pop_front();
                check($sformatf("t2_word_%0d", i), f.word, t2_words[i]);
            end
        end
        check("t2_gap_count", gaps.size(), 4);
        foreach (gaps[i]) check($sformatf("t2_gap_%0d", i), gaps[i], GAP_CYC + 1);
        settle();

        // All 8 addresses with data 0xFF: address field and zero padding
        for (int a = 0; a < 8; a++) begin
            cmd_addr  = 3'(a);
            cmd_data  = 8'hFF;
            cmd_valid = 1'b1;
            guard = 0;
            while (!cmd_ready && guard < 2000) begin
                tick();
                guard++;
            end
            tick();
            cmd_valid = 1'b0;
        end
        wait_frames("t3_frame_count", 8, 2000);
        for (int a = 0; a < 8; a++) begin
            if (frames.size() > 0) begin
                f = frames.pop_front();
                w = {3'(a), 5'b0, 8'hFF};
                check($sformatf("t3_word_%0d", a), f.word, w);
                check($sformatf("t3_pad_%0d", a), f.word[12:8], 0);
            end
        end
        settle();

        // Reset at the 8th SCLK rise with 2 commands still queued
        for (int k = 0; k < 3; k++) begin
            cmd_addr  = 3'(k + 1);
            cmd_data  = 8'h50 + 8'(k);
            cmd_valid = 1'b1;
            tick();
        end
        cmd_valid = 1'b0;
        check("t4_queued", fifo_level, 2);
        guard = 0;
        while (bits_cnt != 8 && guard < 400) begin
            tick();
            guard++;
        end
        check("t4_rise8", bits_cnt, 8);
        rst       = 1'b1;
        cmd_valid = 1'b1;
        cmd_data  = 8'h99;
        tick();
        rst       = 1'b0;
        cmd_valid = 1'b0;
        check("t4_cs_n", spi_cs_n, 1);
        check("t4_sclk", spi_clk, 0);
        check("t4_mosi", spi_mosi, 0);
        check("t4_level", fifo_level, 0);
        check("t4_busy", busy, 0);
        check("t4_aborted_frames", frames.size(), 1);
        if (frames.size() > 0) begin
            f = frames.pop_front();
            check("t4_aborted_bits", f.bits, 8);
        end
        falls_snap = cs_falls;
        repeat (300) tick();
        check("t4_no_frames", frames.size(), 0);
        check("t4_no_cs_fall", cs_falls, falls_snap);
        settle();

        // Random valid with FIFO backpressure, 200 commands, in-order scoreboard
        sent  = 0;
        guard = 0;
        while (sent < 200 && guard < 40000) begin
            cmd_valid = ($urandom_range(0, 3) != 0);
            cmd_addr  = 3'($urandom_range(0, 7));
            cmd_data  = 8'($urandom_range(0, 255));
            if (cmd_valid && cmd_ready) begin
                exp_q.push_back({cmd_addr, 5'b0, cmd_data});
                sent++;
            end
            tick();
            guard++;
        end
        cmd_valid = 1'b0;
        check("t5_sent", sent, 200);
        wait_frames("t5_frame_count", 200, 2000);
        for (int i = 0; i < 200; i++) begin
            if (frames.size() > 0 && exp_q.size() > 0) begin
                f = frames.pop_front();
                w = exp_q.pop_front();
                check($sformatf("t5_word_%0d", i), f.word, w);
            end
        end

        check("mosi_stable_high", mosi_viol, 0);
        check("sclk_idle_cs_high", sclk_viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
